// File: rtl/taxi_eth_port_loopback.sv
// taxi_eth_port_loopback
//   CH_CNT-channel AXI4-Stream frame loopback / cross-connect on a single
//   clock. Each input channel runs in one of three modes, selected at
//   runtime and held for the length of a frame:
//     - drop      : every beat is accepted and discarded
//     - loopback  : input n is sent to output n
//     - pair-swap : input n is sent to output n^1
//   Each output has a two-source frame arbiter, a two-entry skid register
//   and per-input frame counters.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_*              CH_CNT input streams, channel n in slice n
//   m_axis_*              CH_CNT output streams, registered
//   cfg_mode              2 bits per input: 0 drop, 1 loopback, 2 pair-swap,
//                         3 drop
//   stat_fwd_frames       per-input count of forwarded frames
//   stat_drop_frames      per-input count of dropped frames

// One output channel: a frame arbiter choosing between the input with the
// same index (port 0) and its pair partner (port 1), feeding a skid register.
// A beat is packed as {data, keep, user, last}, so bit 0 is tlast.
module taxi_eth_port_loopback_lane #(
  parameter int BW       = 74,
  parameter bit LAST_RST = 1'b1   // reset value of "last granted" port
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic [1:0]         req_i,
  input  logic [1:0][BW-1:0] beat_i,
  output logic [1:0]         rdy_o,
  output logic [BW-1:0]      beat_o,
  output logic               valid_o,
  input  logic               ready_i
);
  logic          busy_q, busy_d, src_q, src_d, last_q, last_d;
  logic          out_vld_q, skid_vld_q;
  logic [BW-1:0] out_q, skid_q, beat_sel;
  logic          sel, push;

  // While idle the grant is decided combinationally, so a new frame can be
  // accepted in the cycle right after the previous frame's tlast.
  always_comb begin
    sel        = busy_q ? src_q : ((&req_i) ? ~last_q : req_i[1]);
    beat_sel   = beat_i[sel];
    rdy_o      = '0;
    rdy_o[sel] = run_i & ~skid_vld_q & (busy_q | (|req_i));
    push       = req_i[sel] & rdy_o[sel];
    busy_d     = busy_q;
    src_d      = src_q;
    last_d     = last_q;
    if (push) begin
      busy_d = ~beat_sel[0];
      src_d  = sel;
      last_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      src_q      <= 1'b0;
      last_q     <= LAST_RST;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      busy_q <= busy_d;
      src_q  <= src_d;
      last_q <= last_d;
      // Output register moves when empty or drained; an accepted beat that
      // arrives while the output is stalled parks in the skid entry, which
      // also closes the input ready for the next cycle.
      if (!out_vld_q || ready_i) begin
        if (skid_vld_q) begin
          out_q      <= skid_q;
          out_vld_q  <= 1'b1;
          skid_vld_q <= 1'b0;
        end else begin
          out_vld_q <= push;
          if (push) out_q <= beat_sel;
        end
      end else if (push) begin
        skid_q     <= beat_sel;
        skid_vld_q <= 1'b1;
      end
    end
  end

  assign beat_o  = out_q;
  assign valid_o = out_vld_q;
endmodule

module taxi_eth_port_loopback #(
  parameter int CH_CNT = 4,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8,
  parameter int USER_W = 1,
  parameter int STAT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CH_CNT*DATA_W-1:0]   s_axis_tdata,
  input  logic [CH_CNT*KEEP_W-1:0]   s_axis_tkeep,
  input  logic [CH_CNT-1:0]          s_axis_tlast,
  input  logic [CH_CNT*USER_W-1:0]   s_axis_tuser,
  input  logic [CH_CNT-1:0]          s_axis_tvalid,
  output logic [CH_CNT-1:0]          s_axis_tready,
  output logic [CH_CNT*DATA_W-1:0]   m_axis_tdata,
  output logic [CH_CNT*KEEP_W-1:0]   m_axis_tkeep,
  output logic [CH_CNT-1:0]          m_axis_tlast,
  output logic [CH_CNT*USER_W-1:0]   m_axis_tuser,
  output logic [CH_CNT-1:0]          m_axis_tvalid,
  input  logic [CH_CNT-1:0]          m_axis_tready,
  input  logic [CH_CNT*2-1:0]        cfg_mode,
  output logic [CH_CNT*STAT_W-1:0]   stat_fwd_frames,
  output logic [CH_CNT*STAT_W-1:0]   stat_drop_frames
);
  localparam int BW = DATA_W + KEEP_W + USER_W + 1;

  logic                           run_q;   // holds ready low until first edge out of reset
  logic [CH_CNT-1:0]              in_frame_q, fwd_q, swp_q;
  logic [CH_CNT-1:0]              fwd, swp, acc;
  logic [CH_CNT-1:0][BW-1:0]      s_beat, m_beat;
  logic [CH_CNT-1:0][1:0]         req, rdy;
  logic [CH_CNT-1:0][STAT_W-1:0]  fwd_cnt_q, drop_cnt_q;

  for (genvar n = 0; n < CH_CNT; n++) begin : g_ch
    // Pair partner; the unpaired last channel of an odd CH_CNT maps to
    // itself and can never be in pair-swap (treated as drop).
    localparam int P     = ((n ^ 1) < CH_CNT) ? (n ^ 1) : n;
    localparam bit HAS_P = (P != n);

    logic [1:0] mode;
    assign mode = cfg_mode[2*n +: 2];

    // Route is the live mode while idle and the latched one mid-frame.
    assign fwd[n] = in_frame_q[n] ? fwd_q[n] : ((mode == 2'd1) || (mode == 2'd2 && HAS_P));
    assign swp[n] = in_frame_q[n] ? swp_q[n] : (mode == 2'd2 && HAS_P);

    assign s_beat[n] = {s_axis_tdata[n*DATA_W +: DATA_W], s_axis_tkeep[n*KEEP_W +: KEEP_W],
                        s_axis_tuser[n*USER_W +: USER_W], s_axis_tlast[n]};

    assign s_axis_tready[n] = !fwd[n] ? run_q : (swp[n] ? rdy[P][1] : rdy[n][0]);
    assign acc[n]           = s_axis_tvalid[n] & s_axis_tready[n];

    // Output n candidates: input n in loopback, partner in pair-swap.
    assign req[n][0] = s_axis_tvalid[n] & fwd[n] & ~swp[n];
    assign req[n][1] = HAS_P ? (s_axis_tvalid[P] & fwd[P] & swp[P]) : 1'b0;

    taxi_eth_port_loopback_lane #(
      .BW       (BW),
      .LAST_RST ((n % 2) == 0)   // even channel of each pair wins first
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .run_i   (run_q),
      .req_i   (req[n]),
      .beat_i  ({s_beat[P], s_beat[n]}),
      .rdy_o   (rdy[n]),
      .beat_o  (m_beat[n]),
      .valid_o (m_axis_tvalid[n]),
      .ready_i (m_axis_tready[n])
    );

    assign m_axis_tdata[n*DATA_W +: DATA_W] = m_beat[n][BW-1 -: DATA_W];
    assign m_axis_tkeep[n*KEEP_W +: KEEP_W] = m_beat[n][USER_W+1 +: KEEP_W];
    assign m_axis_tuser[n*USER_W +: USER_W] = m_beat[n][1 +: USER_W];
    assign m_axis_tlast[n]                  = m_beat[n][0];

    assign stat_fwd_frames[n*STAT_W +: STAT_W]  = fwd_cnt_q[n];
    assign stat_drop_frames[n*STAT_W +: STAT_W] = drop_cnt_q[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      in_frame_q <= '0;
      fwd_q      <= '0;
      swp_q      <= '0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      for (int n = 0; n < CH_CNT; n++) begin
        if (acc[n]) begin
          in_frame_q[n] <= ~s_axis_tlast[n];
          fwd_q[n]      <= fwd[n];
          swp_q[n]      <= swp[n];
          if (s_axis_tlast[n]) begin
            if (fwd[n]) fwd_cnt_q[n]  <= fwd_cnt_q[n] + STAT_W'(1);
            else        drop_cnt_q[n] <= drop_cnt_q[n] + STAT_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_taxi_eth_port_loopback.sv
// Bench for taxi_eth_port_loopback: frame-level scoreboard (per source and
// destination beat queues, frame atomicity, hold-while-stalled), a vector
// table of single frames, directed multi-cycle sequences and a randomized run.
module tb_taxi_eth_port_loopback;
  localparam int CH = 4, DW = 64, KW = 8, UW = 1, SW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH*DW-1:0] s_tdata, m_tdata;
  logic [CH*KW-1:0] s_tkeep, m_tkeep;
  logic [CH*UW-1:0] s_tuser, m_tuser;
  logic [CH-1:0]    s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;
  logic [CH*2-1:0]  cfg_mode;
  logic [CH*SW-1:0] st_fwd, st_drop;

  taxi_eth_port_loopback #(.CH_CNT(CH), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .cfg_mode(cfg_mode), .stat_fwd_frames(st_fwd), .stat_drop_frames(st_drop)
  );

  typedef struct packed {
    logic [DW-1:0] d; logic [KW-1:0] k; logic [UW-1:0] u; logic l;
  } beat_t;

  typedef struct { int ch; logic [1:0] mode; int len; int dst; } vec_t;  // dst -1: dropped

  beat_t q [CH][CH][$];          // accepted beats by [source][destination]
  int    flog [CH][$];           // source of each completed frame per output
  int    total = 0, bad = 0, cyc = 0;
  int    cur_src[CH], out_cnt[CH], acc_cnt[CH], m_fwd[CH], m_drop[CH];
  int    first_pop[CH], last_pop[CH], mf_tgt[CH], rem[CH], flen[CH], e_fwd[CH], e_drop[CH];
  bit    mf_in[CH], acc[CH], prev_stall[CH];
  beat_t prev_beat[CH];
  int    gap_pct = 0, rdy_mode = 0;
  vec_t  tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t obeat(input int k);
    return {m_tdata[k*DW +: DW], m_tkeep[k*KW +: KW], m_tuser[k*UW +: UW], m_tlast[k]};
  endfunction

  function automatic beat_t ibeat(input int n);
    return {s_tdata[n*DW +: DW], s_tkeep[n*KW +: KW], s_tuser[n*UW +: UW], s_tlast[n]};
  endfunction

  // Destination for a frame starting under mode m: -1 means dropped.
  function automatic int live_tgt(input int n, input logic [1:0] m);
    if (m == 2'd1) return n;
    if (m == 2'd2 && (n ^ 1) < CH) return n ^ 1;
    return -1;
  endfunction

  // Reference model, sampled away from the active edge.
  always @(negedge clk) begin
    beat_t got;
    int s, c, t;
    cyc++;
    if (!rst_n) begin
      for (int n = 0; n < CH; n++) begin
        for (int d = 0; d < CH; d++) q[n][d].delete();
        cur_src[n] = -1; mf_in[n] = 0; m_fwd[n] = 0; m_drop[n] = 0;
        acc[n] = 0; prev_stall[n] = 0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        got = obeat(k);
        if (prev_stall[k])
          chk($sformatf("hold_out%0d", k), (m_tvalid[k] && got == prev_beat[k]), 1);
        prev_stall[k] = m_tvalid[k] & ~m_tready[k];
        prev_beat[k]  = got;
        if (m_tvalid[k] && m_tready[k]) begin
          s = -1;
          if (cur_src[k] >= 0) begin
            if (q[cur_src[k]][k].size() > 0 && q[cur_src[k]][k][0] == got) s = cur_src[k];
          end else begin
            for (int j = 0; j < 2; j++) begin
              c = (j == 0) ? k : (k ^ 1);
              if (c < CH && s < 0 && q[c][k].size() > 0 && q[c][k][0] == got) s = c;
            end
          end
          chk($sformatf("out%0d_beat%0d_data=%0h", k, out_cnt[k], got.d), (s >= 0), 1);
          if (s >= 0) begin
            void'(q[s][k].pop_front());
            cur_src[k] = got.l ? -1 : s;
            if (got.l) flog[k].push_back(s);
          end
          out_cnt[k]++;
          if (first_pop[k] < 0) first_pop[k] = cyc;
          last_pop[k] = cyc;
        end
      end
      for (int n = 0; n < CH; n++) begin
        acc[n] = s_tvalid[n] & s_tready[n];
        if (acc[n]) begin
          t = mf_in[n] ? mf_tgt[n] : live_tgt(n, cfg_mode[2*n +: 2]);
          mf_tgt[n] = t;
          if (t >= 0) q[n][t].push_back(ibeat(n));
          acc_cnt[n]++;
          if (s_tlast[n]) begin
            mf_in[n] = 0;
            if (t >= 0) m_fwd[n]++; else m_drop[n]++;
          end else mf_in[n] = 1;
        end
      end
    end
  end

  // One clock of stimulus: hold an unaccepted beat, else present the next.
  task automatic cycle();
    @(posedge clk); #1;
    for (int n = 0; n < CH; n++) begin
      if (!(s_tvalid[n] && !acc[n])) begin
        if (rem[n] > 0 && $urandom_range(99) >= gap_pct) begin
          s_tdata[n*DW +: DW] = {$urandom, $urandom};
          s_tkeep[n*KW +: KW] = KW'($urandom);
          s_tuser[n*UW +: UW] = UW'($urandom);
          s_tlast[n]  = ((rem[n] - 1) % flen[n]) == 0;
          s_tvalid[n] = 1'b1;
          rem[n]--;
        end else s_tvalid[n] = 1'b0;
      end
      case (rdy_mode)
        0:       m_tready[n] = 1'b1;
        1:       m_tready[n] = ~m_tready[n];
        default: m_tready[n] = 1'($urandom_range(1));
      endcase
    end
  endtask

  function automatic bit is_idle();
    for (int n = 0; n < CH; n++) begin
      if (rem[n] != 0 || s_tvalid[n] || m_tvalid[n]) return 0;
      for (int d = 0; d < CH; d++) if (q[n][d].size() != 0) return 0;
    end
    return 1;
  endfunction

  task automatic drain(input string nm);
    bit idle;
    idle = is_idle();
    for (int i = 0; i < 1000 && !idle; i++) begin
      cycle();
      idle = is_idle();
    end
    chk({nm, "_drain"}, idle, 1);
  endtask

  task automatic check_e(input string nm);
    for (int n = 0; n < CH; n++) begin
      chk($sformatf("%s_fwd%0d", nm, n), st_fwd[n*SW +: SW], 64'(e_fwd[n]));
      chk($sformatf("%s_drop%0d", nm, n), st_drop[n*SW +: SW], 64'(e_drop[n]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob[CH];
    int a0;
    s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0; s_tvalid = '0;
    m_tready = '1; cfg_mode = '0;
    for (int n = 0; n < CH; n++) begin flen[n] = 1; rem[n] = 0; first_pop[n] = -1; end
    tbl[0] = '{0, 2'd1, 9, 0};  tbl[1] = '{1, 2'd1, 9, 1};
    tbl[2] = '{0, 2'd2, 8, 1};  tbl[3] = '{1, 2'd2, 8, 0};
    tbl[4] = '{2, 2'd0, 5, -1}; tbl[5] = '{3, 2'd3, 3, -1};
    tbl[6] = '{3, 2'd2, 1, 2};  tbl[7] = '{2, 2'd1, 1, 2};

    repeat (3) @(posedge clk); #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_stat_fwd", st_fwd, 0);
    chk("rst_stat_drop", st_drop, 0);
    rst_n = 1'b1;

    // Single frames from the vector table.
    for (int i = 0; i < 8; i++) begin
      ob = out_cnt;
      cfg_mode[2*tbl[i].ch +: 2] = tbl[i].mode;
      flen[tbl[i].ch] = tbl[i].len;
      rem[tbl[i].ch]  = tbl[i].len;
      drain($sformatf("vec%0d", i));
      for (int k = 0; k < CH; k++)
        chk($sformatf("vec%0d_out%0d_beats", i, k), 64'(out_cnt[k] - ob[k]),
            (k == tbl[i].dst) ? 64'(tbl[i].len) : 64'd0);
      if (tbl[i].dst >= 0) e_fwd[tbl[i].ch]++; else e_drop[tbl[i].ch]++;
      check_e($sformatf("vec%0d", i));
    end

    // Self-loopback on every channel, with first-beat latency.
    cfg_mode = {CH{2'b01}};
    ob = out_cnt;
    for (int n = 0; n < CH; n++) begin flen[n] = 9; rem[n] = 9; end
    cycle(); @(negedge clk);
    chk("lb_lat0_valid", m_tvalid, 0);
    chk("lb_first_ready", s_tready, 4'hF);
    cycle(); @(negedge clk);
    chk("lb_lat1_valid", m_tvalid, 4'hF);
    drain("lb");
    for (int n = 0; n < CH; n++) begin
      chk($sformatf("lb_out%0d_beats", n), 64'(out_cnt[n] - ob[n]), 9);
      e_fwd[n]++;
    end
    check_e("lb");

    // Contention on output 0: ch0 loopback vs ch1 pair-swap.
    cfg_mode = '0; cfg_mode[1:0] = 2'd1; cfg_mode[3:2] = 2'd2;
    flog[0].delete(); first_pop[0] = -1;
    flen[0] = 3; flen[1] = 3; rem[0] = 9; rem[1] = 9;
    drain("ct");
    chk("ct_frames", flog[0].size(), 6);
    for (int i = 1; i < flog[0].size(); i++)
      chk($sformatf("ct_alt%0d", i), (flog[0][i] == flog[0][i-1]), 0);
    chk("ct_span", 64'(last_pop[0] - first_pop[0] + 1), 18);
    e_fwd[0] += 3; e_fwd[1] += 3;
    check_e("ct");

    // Mode change mid-frame takes effect at the next frame.
    cfg_mode = '0; cfg_mode[5:4] = 2'd1;
    ob = out_cnt; a0 = acc_cnt[2];
    flen[2] = 10; rem[2] = 10;
    for (int i = 0; i < 50 && acc_cnt[2] - a0 < 4; i++) cycle();
    chk("md_wait", (acc_cnt[2] - a0 >= 4), 1);
    cfg_mode[5:4] = 2'd0;
    drain("md1");
    chk("md_out2_beats", 64'(out_cnt[2] - ob[2]), 10);
    e_fwd[2]++;
    ob = out_cnt;
    flen[2] = 6; rem[2] = 6;
    for (int i = 0; i < 20 && (rem[2] != 0 || s_tvalid[2]); i++) begin
      cycle(); #1;
      if (s_tvalid[2]) chk($sformatf("md_drop_ready%0d", i), s_tready[2], 1);
    end
    drain("md2");
    chk("md_out2_none", 64'(out_cnt[2] - ob[2]), 0);
    e_drop[2]++;
    check_e("md");

    // Output backpressure toggling every cycle.
    cfg_mode = '0; cfg_mode[1:0] = 2'd1;
    ob = out_cnt; rdy_mode = 1;
    flen[0] = 20; rem[0] = 20;
    drain("bp");
    rdy_mode = 0;
    chk("bp_out0_beats", 64'(out_cnt[0] - ob[0]), 20);
    e_fwd[0]++;
    check_e("bp");

    // Reset in the middle of a frame.
    cfg_mode = '0; cfg_mode[3:2] = 2'd1;
    a0 = acc_cnt[1];
    flen[1] = 10; rem[1] = 10;
    for (int i = 0; i < 50 && acc_cnt[1] - a0 < 5; i++) cycle();
    chk("rs_wait", (acc_cnt[1] - a0 >= 5), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_m_tvalid", m_tvalid, 0);
    chk("rs_s_tready", s_tready, 0);
    chk("rs_stat_fwd", st_fwd, 0);
    chk("rs_stat_drop", st_drop, 0);
    for (int n = 0; n < CH; n++) begin rem[n] = 0; e_fwd[n] = 0; e_drop[n] = 0; end
    s_tvalid = '0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    ob = out_cnt;
    flen[1] = 4; rem[1] = 4;
    drain("rs");
    chk("rs_out1_beats", 64'(out_cnt[1] - ob[1]), 4);
    e_fwd[1] = 1;
    check_e("rs");

    // Randomized traffic, modes, gaps and backpressure.
    gap_pct = 20; rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19) == 0) cfg_mode[2*$urandom_range(CH-1) +: 2] = 2'($urandom);
      for (int n = 0; n < CH; n++)
        if (rem[n] == 0 && $urandom_range(9) == 0) begin
          flen[n] = $urandom_range(12, 1);
          rem[n]  = flen[n];
        end
      cycle();
    end
    gap_pct = 0; rdy_mode = 0;
    drain("rnd");
    for (int n = 0; n < CH; n++) begin
      chk($sformatf("rnd_fwd%0d", n), st_fwd[n*SW +: SW], 64'(m_fwd[n]));
      chk($sformatf("rnd_drop%0d", n), st_drop[n*SW +: SW], 64'(m_drop[n]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/taxi_eth_port_loopback.md
Name: taxi_eth_port_loopback

Overview:
- Single-clock, CH_CNT-channel AXI4-Stream frame loopback/cross-connect engine; successor to the fixed per-port rx->tx loopback used in board bring-up cores.
- Sits between the MAC RX/TX streams after clock-domain crossing, so all channels share one clock.
- Per-channel runtime mode: drop, self-loopback, or pair-swap (n <-> n^1).
- Frame-atomic mode switching, per-output two-source frame arbitration, registered outputs and per-channel frame statistics.

Parameters:
- CH_CNT, 4, number of channels (>=1).
- DATA_W, 64, tdata width per channel.
- KEEP_W, DATA_W/8, tkeep width per channel.
- USER_W, 1, tuser width per channel, passed through unmodified.
- STAT_W, 32, frame counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  CH_CNT*DATA_W  input data, channel n at [n*DATA_W +: DATA_W]
- s_axis_tkeep  in  CH_CNT*KEEP_W  input byte enables
- s_axis_tlast  in  CH_CNT  input end of frame
- s_axis_tuser  in  CH_CNT*USER_W  input sideband
- s_axis_tvalid  in  CH_CNT  input valid
- s_axis_tready  out  CH_CNT  input ready
- m_axis_tdata  out  CH_CNT*DATA_W  output data
- m_axis_tkeep  out  CH_CNT*KEEP_W  output byte enables
- m_axis_tlast  out  CH_CNT  output end of frame
- m_axis_tuser  out  CH_CNT*USER_W  output sideband
- m_axis_tvalid  out  CH_CNT  output valid
- m_axis_tready  in  CH_CNT  output ready
- cfg_mode  in  CH_CNT*2  per-input mode: 0 drop, 1 loopback, 2 pair-swap, 3 drop (reserved)
- stat_fwd_frames  out  CH_CNT*STAT_W  per-input forwarded frame count
- stat_drop_frames  out  CH_CNT*STAT_W  per-input dropped frame count

Behaviour:
- Reset (rst_n low, async):
  - m_axis_tvalid=0, s_axis_tready=0, all counters=0, all grants released.
  - Every input is idle (next beat is a frame start); arbiter priority goes to the even channel of each pair.
  - Reset mid-frame abandons the partial frame with no tlast emitted. Outputs release on the first clk edge after rst_n rises.
- Mode latch:
  - Each input holds frame state {idle, in_frame} and a latched mode.
  - While idle, the effective mode is the live cfg_mode. The mode is latched on the first accepted beat and held until the tlast beat is accepted.
  - A cfg_mode change mid-frame takes effect at the next frame.
  - Pair-swap on a channel with no partner (CH_CNT odd, last channel) is treated as drop.
- Drop mode:
  - s_axis_tready=1 unconditionally; beats are discarded.
  - stat_drop_frames[n] increments on the accepted tlast beat.
- Routing:
  - Target output = n (loopback) or n^1 (pair-swap).
  - Output k therefore has at most two candidate sources: input k in loopback and input k^1 in pair-swap.
- Arbiter, per output:
  - States IDLE and BUSY(src).
  - IDLE with one requester (tvalid and effective mode targeting k): grant that requester.
  - IDLE with two requesters: grant the one not granted last (round-robin).
  - Grant holds until the source's tlast beat is accepted; the arbiter then returns to IDLE and may re-grant in the same cycle (no idle bubble).
  - A non-granted source sees tready=0.
- Output stage: two-entry skid register per output.
  - s_axis_tready(granted src) = skid not full; it does not depend combinationally on m_axis_tready.
  - Latency: input accept to m_axis_tvalid is 1 cycle. Sustains 1 beat/cycle when m_axis_tready=1.
  - tdata/tkeep/tlast/tuser are forwarded unmodified; tuser error bits are not acted upon.
  - Outputs are held stable while tvalid=1 and tready=0.
- Statistics:
  - stat_fwd_frames[n] increments when input n's forwarded tlast beat is accepted at the input.
  - Counters wrap modulo 2^STAT_W.
  - A simultaneous drop and forward increment on different channels are independent.
- Simultaneous events: the tlast of the granted source and the first beat of the other source in the same cycle means the grant passes to the waiting source on the next cycle; no beat is lost or duplicated.

Test Plan:
- Self-loopback: CH_CNT=4, all cfg_mode=1, one 9-beat frame on each input with m_axis_tready=1 -> each output emits the identical 9 beats starting 1 cycle later; stat_fwd_frames=1 each, stat_drop_frames=0.
- Pair-swap: mode 2 on ch0 and ch1, 64-byte frames -> ch0 data appears on m1 and ch1 data on m0; m2/m3 idle.
- Contention: ch0 mode 1 and ch1 mode 2, back-to-back 3-beat frames on both -> m0 alternates frames ch0, ch1, ch0 ... with no interleaved beats and no idle cycle between frames.
- Mid-frame mode change: ch2 switches mode 1 -> 0 at beat 4 of a 10-beat frame -> all 10 beats delivered on m2; the next frame is dropped with s_axis_tready=1 and stat_drop_frames[2]=1.
- Backpressure: m_axis_tready toggles 1/0 every cycle during a 20-beat frame -> the output sequence is exact, with no beat change while stalled.
- Reset mid-frame: assert rst_n low at beat 5 -> m_axis_tvalid=0 asynchronously and counters=0; after release, a new 4-beat frame forwards correctly and stat_fwd_frames=1.
